// File: rtl/accel_bus_scheduler.sv
// Round-robin time-slicer for the shared RAM data bus between the FFT, FIR and IIR
// accelerators, with a bounded quantum and a forced one-cycle all-off gap between grants.
module accel_bus_scheduler #(
   parameter int QUANTUM = 16,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sched_enable,
   input  logic             fft_req,
   input  logic             fir_req,
   input  logic             iir_req,
   input  logic             to_fft_empty,
   input  logic             to_fft_full,
   input  logic             from_fft_empty,
   input  logic             from_fft_full,
   input  logic             to_fir_empty,
   input  logic             to_fir_full,
   input  logic             from_fir_empty,
   input  logic             from_fir_full,
   input  logic             to_iir_empty,
   input  logic             to_iir_full,
   input  logic             from_iir_empty,
   input  logic             from_iir_full,
   output logic             fft_enable,
   output logic             fir_enable,
   output logic             iir_enable,
   output logic [1:0]       grant_id,
   output logic [CNT_W-1:0] slot_count,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   localparam logic [1:0] ID_FFT  = 2'd0;
   localparam logic [1:0] ID_FIR  = 2'd1;
   localparam logic [1:0] ID_IIR  = 2'd2;
   localparam logic [1:0] ID_NONE = 2'd3;
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(QUANTUM - 1);

   state_t     state;
   logic [1:0] last;
   logic [2:0] elig;
   logic [1:0] win_id;
   logic       win_valid;
   logic       elig_cur;

   // An accelerator is eligible only with something to move and self-consistent FIFO flags.
   assign elig[0] = sched_enable & fft_req & ~(to_fft_full & from_fft_empty)
                    & ~(to_fft_empty & to_fft_full) & ~(from_fft_empty & from_fft_full);
   assign elig[1] = sched_enable & fir_req & ~(to_fir_full & from_fir_empty)
                    & ~(to_fir_empty & to_fir_full) & ~(from_fir_empty & from_fir_full);
   assign elig[2] = sched_enable & iir_req & ~(to_iir_full & from_iir_empty)
                    & ~(to_iir_empty & to_iir_full) & ~(from_iir_empty & from_iir_full);

   assign win_valid = |elig;

   // Search starts just after the last winner so every requester is served in turn.
   always_comb begin
      win_id = ID_NONE;
      case (last)
         ID_FFT: begin
            if (elig[1])      win_id = ID_FIR;
            else if (elig[2]) win_id = ID_IIR;
            else if (elig[0]) win_id = ID_FFT;
         end
         ID_FIR: begin
            if (elig[2])      win_id = ID_IIR;
            else if (elig[0]) win_id = ID_FFT;
            else if (elig[1]) win_id = ID_FIR;
         end
         default: begin
            if (elig[0])      win_id = ID_FFT;
            else if (elig[1]) win_id = ID_FIR;
            else if (elig[2]) win_id = ID_IIR;
         end
      endcase
   end

   always_comb begin
      elig_cur = 1'b0;
      case (grant_id)
         ID_FFT:  elig_cur = elig[0];
         ID_FIR:  elig_cur = elig[1];
         ID_IIR:  elig_cur = elig[2];
         default: elig_cur = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         last       <= ID_IIR;
         grant_id   <= ID_NONE;
         slot_count <= '0;
         fft_enable <= 1'b0;
         fir_enable <= 1'b0;
         iir_enable <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state)
            GRANT: begin
               // Leaving GRANT always passes through GAP so two bus drivers never overlap.
               if (!elig_cur || !sched_enable || slot_count == SLOT_LAST) begin
                  state      <= GAP;
                  grant_id   <= ID_NONE;
                  slot_count <= '0;
                  fft_enable <= 1'b0;
                  fir_enable <= 1'b0;
                  iir_enable <= 1'b0;
                  busy       <= 1'b0;
               end else begin
                  slot_count <= slot_count + CNT_W'(1);
               end
            end
            default: begin
               if (win_valid) begin
                  state      <= GRANT;
                  last       <= win_id;
                  grant_id   <= win_id;
                  slot_count <= '0;
                  fft_enable <= (win_id == ID_FFT);
                  fir_enable <= (win_id == ID_FIR);
                  iir_enable <= (win_id == ID_IIR);
                  busy       <= 1'b1;
               end else begin
                  state      <= IDLE;
                  grant_id   <= ID_NONE;
                  slot_count <= '0;
                  fft_enable <= 1'b0;
                  fir_enable <= 1'b0;
                  iir_enable <= 1'b0;
                  busy       <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accel_bus_scheduler.sv
// Self-checking bench for accel_bus_scheduler with QUANTUM=4: a vector table plus
// hand-written multi-cycle sequences, expectations queued and checked one cycle later.
module tb_accel_bus_scheduler;

   localparam int QUANTUM = 4;
   localparam int CNT_W   = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic sched_enable;
   logic fft_req, fir_req, iir_req;
   logic to_fft_empty, to_fft_full, from_fft_empty, from_fft_full;
   logic to_fir_empty, to_fir_full, from_fir_empty, from_fir_full;
   logic to_iir_empty, to_iir_full, from_iir_empty, from_iir_full;
   logic fft_enable, fir_enable, iir_enable;
   logic [1:0] grant_id;
   logic [CNT_W-1:0] slot_count;
   logic busy;

   always #5 clk = ~clk;

   accel_bus_scheduler #(.QUANTUM(QUANTUM), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .sched_enable(sched_enable),
      .fft_req(fft_req), .fir_req(fir_req), .iir_req(iir_req),
      .to_fft_empty(to_fft_empty), .to_fft_full(to_fft_full),
      .from_fft_empty(from_fft_empty), .from_fft_full(from_fft_full),
      .to_fir_empty(to_fir_empty), .to_fir_full(to_fir_full),
      .from_fir_empty(from_fir_empty), .from_fir_full(from_fir_full),
      .to_iir_empty(to_iir_empty), .to_iir_full(to_iir_full),
      .from_iir_empty(from_iir_empty), .from_iir_full(from_iir_full),
      .fft_enable(fft_enable), .fir_enable(fir_enable), .iir_enable(iir_enable),
      .grant_id(grant_id), .slot_count(slot_count), .busy(busy)
   );

   typedef struct {
      logic       se;
      logic [2:0] req;
      logic [11:0] flags;
      logic [2:0] exp_en;
      logic [1:0] exp_gid;
      logic [7:0] exp_slot;
   } vec_t;

   typedef struct {
      string      name;
      logic [2:0] en;
      logic [1:0] gid;
      logic [7:0] slot;
      logic       busy;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int tests_run = 0;
   int tests_failed = 0;

   // req is {fft,fir,iir}; flags are three nibbles {to_empty,to_full,from_empty,from_full}
   // for FFT, FIR, IIR from the top down; enables are {fft,fir,iir}.
   task automatic driveInputs(input logic se, input logic [2:0] req, input logic [11:0] flags);
      sched_enable = se;
      {fft_req, fir_req, iir_req} = req;
      {to_fft_empty, to_fft_full, from_fft_empty, from_fft_full,
       to_fir_empty, to_fir_full, from_fir_empty, from_fir_full,
       to_iir_empty, to_iir_full, from_iir_empty, from_iir_full} = flags;
   endtask

   task automatic pushExpected(input string name, input logic [2:0] en,
                               input logic [1:0] gid, input logic [7:0] slot);
      exp_t e;
      e.name = name;
      e.en   = en;
      e.gid  = gid;
      e.slot = slot;
      e.busy = |en;
      sb_q.push_back(e);
   endtask

   task automatic checkOutput();
      exp_t e;
      logic [13:0] act, want;
      tests_run++;
      if (sb_q.size() == 0) begin
         tests_failed++;
         $display("[TB] FAIL scoreboard_empty: no expected entry queued");
         return;
      end
      e = sb_q.pop_front();
      act  = {fft_enable, fir_enable, iir_enable, grant_id, slot_count, busy};
      want = {e.en, e.gid, e.slot, e.busy};
      if (act !== want) begin
         tests_failed++;
         $display("[TB] FAIL %s: got en=%b gid=%b slot=%0d busy=%b, want en=%b gid=%b slot=%0d busy=%b",
                  e.name, act[13:11], act[10:9], act[8:1], act[0],
                  e.en, e.gid, e.slot, e.busy);
      end
   endtask

   task automatic applyStimulus(input string name, input logic se, input logic [2:0] req,
                                input logic [11:0] flags, input logic [2:0] en,
                                input logic [1:0] gid, input logic [7:0] slot);
      driveInputs(se, req, flags);
      pushExpected(name, en, gid, slot);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   task automatic addVec(input logic se, input logic [2:0] req, input logic [11:0] flags,
                         input logic [2:0] en, input logic [1:0] gid, input logic [7:0] slot);
      vec_t v;
      v.se = se; v.req = req; v.flags = flags;
      v.exp_en = en; v.exp_gid = gid; v.exp_slot = slot;
      vecs.push_back(v);
   endtask

   task automatic doReset();
      reset = 1'b0;
      driveInputs(1'b0, 3'b000, 12'h000);
      repeat (2) @(posedge clk);
      #1;
      pushExpected("reset_state", 3'b000, 2'b11, 8'd0);
      checkOutput();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      int order[4];
      logic [2:0] oh;

      // Lone FIR requester: two full quanta separated by a single gap, then back to idle.
      for (int s = 0; s < 4; s++) addVec(1, 3'b010, 12'h000, 3'b010, 2'b01, 8'(s));
      addVec(1, 3'b010, 12'h000, 3'b000, 2'b11, 8'd0);
      for (int s = 0; s < 4; s++) addVec(1, 3'b010, 12'h000, 3'b010, 2'b01, 8'(s));
      addVec(1, 3'b010, 12'h000, 3'b000, 2'b11, 8'd0);
      addVec(1, 3'b000, 12'h000, 3'b000, 2'b11, 8'd0);
      // Inconsistent or deadlocked flags, and a disabled scheduler, keep the bus idle.
      addVec(1, 3'b100, 12'hC00, 3'b000, 2'b11, 8'd0);
      addVec(1, 3'b100, 12'hC00, 3'b000, 2'b11, 8'd0);
      addVec(1, 3'b010, 12'h030, 3'b000, 2'b11, 8'd0);
      addVec(1, 3'b001, 12'h006, 3'b000, 2'b11, 8'd0);
      addVec(0, 3'b111, 12'h000, 3'b000, 2'b11, 8'd0);
      // Legal non-zero flags grant IIR; a deadlock flag pattern then releases it.
      addVec(1, 3'b001, 12'h005, 3'b001, 2'b10, 8'd0);
      addVec(1, 3'b001, 12'h006, 3'b000, 2'b11, 8'd0);
      addVec(1, 3'b001, 12'h006, 3'b000, 2'b11, 8'd0);

      doReset();
      for (int i = 0; i < vecs.size(); i++)
         applyStimulus($sformatf("tbl%0d", i), vecs[i].se, vecs[i].req, vecs[i].flags,
                       vecs[i].exp_en, vecs[i].exp_gid, vecs[i].exp_slot);

      // All three request: rotation FFT, FIR, IIR, FFT with one gap cycle between.
      doReset();
      order = '{0, 1, 2, 0};
      for (int g = 0; g < 4; g++) begin
         oh = 3'b100 >> order[g];
         for (int s = 0; s < 4; s++)
            applyStimulus($sformatf("rr%0d_s%0d", g, s), 1, 3'b111, 12'h000,
                          oh, 2'(order[g]), 8'(s));
         applyStimulus($sformatf("rr%0d_gap", g), 1, 3'b111, 12'h000, 3'b000, 2'b11, 8'd0);
      end

      // FFT loses eligibility at slot 1; FIR follows after one gap.
      doReset();
      applyStimulus("elig_fft_s0", 1, 3'b110, 12'h000, 3'b100, 2'b00, 8'd0);
      applyStimulus("elig_fft_s1", 1, 3'b110, 12'h000, 3'b100, 2'b00, 8'd1);
      applyStimulus("elig_gap",    1, 3'b110, 12'h600, 3'b000, 2'b11, 8'd0);
      applyStimulus("elig_fir_s0", 1, 3'b110, 12'h600, 3'b010, 2'b01, 8'd0);

      // sched_enable drops during an IIR grant; FFT wins once it returns.
      doReset();
      applyStimulus("sen_iir_s0", 1, 3'b001, 12'h000, 3'b001, 2'b10, 8'd0);
      applyStimulus("sen_iir_s1", 1, 3'b001, 12'h000, 3'b001, 2'b10, 8'd1);
      applyStimulus("sen_iir_s2", 1, 3'b001, 12'h000, 3'b001, 2'b10, 8'd2);
      applyStimulus("sen_drop",   0, 3'b111, 12'h000, 3'b000, 2'b11, 8'd0);
      for (int i = 0; i < 3; i++)
         applyStimulus($sformatf("sen_off%0d", i), 0, 3'b111, 12'h000, 3'b000, 2'b11, 8'd0);
      applyStimulus("sen_back_fft", 1, 3'b111, 12'h000, 3'b100, 2'b00, 8'd0);

      // Reset asserted mid FIR grant clears outputs at once; FFT has priority afterwards.
      doReset();
      for (int s = 0; s < 4; s++)
         applyStimulus($sformatf("rst_fir_s%0d", s), 1, 3'b010, 12'h000, 3'b010, 2'b01, 8'(s));
      #2;
      reset = 1'b0;
      #1;
      pushExpected("rst_async", 3'b000, 2'b11, 8'd0);
      checkOutput();
      @(negedge clk);
      reset = 1'b1;
      applyStimulus("rst_after_fft", 1, 3'b111, 12'h000, 3'b100, 2'b00, 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/accel_bus_scheduler.md
# accel_bus_scheduler

Time-slices the shared 32-bit RAM data bus between the FFT, FIR and IIR accelerators. It drives the one-hot `fft_enable`/`fir_enable`/`iir_enable` inputs of `data_bus_controller` from per-accelerator service requests and FIFO flags. Arbitration is round-robin with a bounded time quantum and a mandatory one-cycle all-off turnaround between grants, so two tri-state drivers never overlap on `data_bus`.

## Interface
- `QUANTUM`, 16, maximum consecutive cycles one accelerator holds the bus (legal 2..255)
- `CNT_W`, 8, width of the slot counter; must satisfy 2^CNT_W ≥ QUANTUM
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sched_enable`  in  1  global enable; low blocks new grants and ends the current grant
- `fft_req`, `fir_req`, `iir_req`  in  1 each  level request: accelerator wants bus service
- `to_fft_empty`, `to_fft_full`, `from_fft_empty`, `from_fft_full`  in  1 each  FFT FIFO flags (same flag set for `fir`, `iir`)
- `fft_enable`, `fir_enable`, `iir_enable`  out  1 each  registered grant, at most one high
- `grant_id`  out  2  00 FFT, 01 FIR, 10 IIR, 11 none; registered, matches enables
- `slot_count`  out  CNT_W  cycles elapsed in current grant (0 on first grant cycle)
- `busy`  out  1  high while any enable is high

## Operation
- Eligibility (combinational, per accelerator X): `elig_X = sched_enable & X_req & ~(to_X_full & from_X_empty) & ~(to_X_empty & to_X_full) & ~(from_X_empty & from_X_full)`. This excludes the deadlock case (nothing to move) and inconsistent flags.
- Round-robin pointer `last`, 2 bits. Search order starts at `last+1` (mod 3: FFT→FIR→IIR→FFT). The first eligible accelerator wins. `last` updates to the winner on every grant. Reset value is IIR, so FFT has first priority.
- States:
  - IDLE: no grant. If any `elig`, go to GRANT with the winner; otherwise stay.
  - GRANT: the winner's enable is high and `slot_count` increments each cycle. Go to GAP when any of these holds:
    - `elig_winner` is low;
    - `slot_count == QUANTUM-1` (the quantum is used up);
    - `sched_enable` is low.
  - GAP: all enables low, `grant_id`=11. Arbitrate exactly as in IDLE: go to GRANT if any `elig`, else to IDLE.
- The same accelerator may be re-granted after a GAP if it is the only eligible one.
- Requests that arrive while another accelerator holds the bus wait. There is no preemption before the quantum ends, except through loss of eligibility or `sched_enable`.
- Enables, `grant_id`, `busy` and `slot_count` come straight from registers; no combinational path from inputs to outputs.

## Timing
- Reset (async assert, sync release): state IDLE; all enables 0; `grant_id`=11; `slot_count`=0; `busy`=0; `last`=IIR.
- Grant latency: if `elig` is high at rising edge N while in IDLE or GAP, the enable is high from edge N through edge N+1 (one cycle after eligibility is sampled).
- Release latency: if the exit condition is true at edge M in GRANT, the enable is low after edge M.
- Full quantum: with eligibility held, an enable is high for exactly QUANTUM cycles, then low for exactly 1 cycle.
- Turnaround: between any two grants, all enables are low for ≥1 cycle. There is never a cycle with two enables high.
- Simultaneous events:
  - Quantum expiry and eligibility drop on the same edge: a single exit to GAP.
  - New requests during GAP are considered at that GAP edge.
- Reset mid-grant: enables drop asynchronously on assertion. After release, arbitration restarts from FFT priority.

## Test plan
- Reset, QUANTUM=4, `sched_enable`=1, only `fir_req`=1 with flags 0000 → `fir_enable` high for cycles 1–4, low in cycle 5, high again in cycles 6–9; `grant_id` alternates 01/11.
- All three requests high, flags 0000, QUANTUM=4 → grant order FFT, FIR, IIR, FFT; each enable high for 4 cycles with 1 idle cycle between; never two enables high.
- FFT granted; at `slot_count`=1, drive `to_fft_full`=1 and `from_fft_empty`=1 → `fft_enable` low next cycle, one GAP cycle, then FIR granted if `fir_req`=1.
- FFT flags `to_fft_empty`=1 and `to_fft_full`=1 with `fft_req`=1, no other requests → no enable asserted; state stays IDLE; `grant_id`=11.
- `sched_enable` dropped at `slot_count`=2 during an IIR grant → `iir_enable` low next cycle; no further grants until `sched_enable` returns; then FFT is granted first (pointer after IIR).
- `reset` asserted mid-grant (FIR, `slot_count`=3) → all enables 0 immediately; after release with all requests high, FFT is granted first.
